// File: rtl/line_buffer_ctrl.sv
// Sequencer for line_buffer: streams M*W bytes into the buffer, then reads out every stride-m window.
// Write path adds 1 cycle; each window takes REQ, CAPT, HOLD (>=3 cycles); s_ready is high only in FILL and HOLD stalls on i_win_ready.
module line_buffer_ctrl #(
    parameter int M      = 3,
    parameter int W      = 10,
    parameter int n      = 4,
    parameter int m      = 2,
    parameter int SETTLE = 1
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_start,
    input  logic [7:0]                          s_data,
    input  logic                                s_valid,
    output logic                                s_ready,
    output logic [7:0]                          o_lb_data,
    output logic                                o_lb_data_valid,
    output logic                                o_lb_read,
    input  logic [M*n*8-1:0]                    i_lb_window,
    input  logic                                i_lb_finish_reading,
    output logic [M*n*8-1:0]                    o_win_data,
    output logic                                o_win_valid,
    input  logic                                i_win_ready,
    output logic [$clog2((W-n)/m+2)-1:0]        o_win_idx,
    output logic                                o_busy,
    output logic                                o_done
);
    localparam int NW = (W - n) / m + 1;
    localparam int CW = $clog2(M * W + 1);
    localparam int IW = $clog2(NW + 1);
    localparam int SW = $clog2(SETTLE + 1);
    localparam int WB = M * n * 8;
    localparam logic [CW-1:0] LAST_BEAT = CW'(M * W - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NW - 1);
    localparam logic [SW-1:0] LAST_SET  = SW'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_SETTLE, S_REQ, S_CAPT, S_HOLD, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic [SW-1:0]   scnt_q, scnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            fin_q, fin_d;
    logic [7:0]      lb_data_q, lb_data_d;
    logic            lb_dv_q, lb_dv_d;
    logic [WB-1:0]   win_data_q, win_data_d;
    logic            win_valid_q, win_valid_d;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            wcnt_q      <= '0;
            scnt_q      <= '0;
            idx_q       <= '0;
            fin_q       <= 1'b0;
            lb_data_q   <= '0;
            lb_dv_q     <= 1'b0;
            win_data_q  <= '0;
            win_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            scnt_q      <= scnt_d;
            idx_q       <= idx_d;
            fin_q       <= fin_d;
            lb_data_q   <= lb_data_d;
            lb_dv_q     <= lb_dv_d;
            win_data_q  <= win_data_d;
            win_valid_q <= win_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        scnt_d      = scnt_q;
        idx_d       = idx_q;
        fin_d       = fin_q;
        lb_data_d   = lb_data_q;
        lb_dv_d     = 1'b0;
        win_data_d  = win_data_q;
        win_valid_d = win_valid_q;
        s_ready     = 1'b0;
        o_lb_read   = 1'b0;
        o_done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_FILL;
                    wcnt_d  = '0;
                    idx_d   = '0;
                    fin_d   = 1'b0;
                end
            end
            S_FILL: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    lb_data_d = s_data;
                    lb_dv_d   = 1'b1;
                    wcnt_d    = wcnt_q + CW'(1);
                    if (wcnt_q == LAST_BEAT) begin
                        state_d = S_SETTLE;
                        scnt_d  = '0;
                    end
                end
            end
            S_SETTLE: begin
                // SETTLE>=1 guarantees the final write never overlaps the first read
                if (scnt_q == LAST_SET) state_d = S_REQ;
                else                    scnt_d  = scnt_q + SW'(1);
            end
            S_REQ: begin
                o_lb_read = 1'b1;
                fin_d     = fin_q | i_lb_finish_reading;
                state_d   = S_CAPT;
            end
            S_CAPT: begin
                fin_d       = fin_q | i_lb_finish_reading;
                win_data_d  = i_lb_window;
                win_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                fin_d = fin_q | i_lb_finish_reading;
                if (win_valid_q && i_win_ready) begin
                    win_valid_d = 1'b0;
                    if (idx_q == LAST_IDX || fin_q || i_lb_finish_reading) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        fin_d   = 1'b0;
                        state_d = S_REQ;
                    end
                end
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_lb_data       = lb_data_q;
    assign o_lb_data_valid = lb_dv_q;
    assign o_win_data      = win_data_q;
    assign o_win_valid     = win_valid_q;
    assign o_win_idx       = idx_q;
    assign o_busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl: behavioural line buffer plus write/window scoreboards, three parameter sets.
module tb_line_buffer_ctrl;
    localparam int M = 3, W = 10, N = 4, MS = 2, NW = 4, WB = M * N * 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n = 1'b0, start = 1'b0;
    logic [7:0]      s_data = 8'd0;
    logic            s_valid = 1'b0, s_ready;
    logic [7:0]      lb_data;
    logic            lb_dv, lb_read, lb_fin;
    logic [WB-1:0]   lb_win = '0;
    logic [WB-1:0]   win_data;
    logic            win_valid, win_ready = 1'b1;
    logic [2:0]      win_idx;
    logic            busy, done;

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Window of a buffer filled with byte value = row*w + col, byte 0 in the MSBs
    function automatic logic [191:0] mkwin(input int w, input int nn, input int col);
        logic [191:0] v = '0;
        for (int r = 0; r < 3; r++)
            for (int j = 0; j < nn; j++)
                v[(3 * nn - 1 - (r * nn + j)) * 8 +: 8] = 8'(r * w + col + j);
        return v;
    endfunction

    line_buffer_ctrl #(.M(M), .W(W), .n(N), .m(MS), .SETTLE(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .o_lb_data(lb_data), .o_lb_data_valid(lb_dv), .o_lb_read(lb_read),
        .i_lb_window(lb_win), .i_lb_finish_reading(lb_fin),
        .o_win_data(win_data), .o_win_valid(win_valid), .i_win_ready(win_ready),
        .o_win_idx(win_idx), .o_busy(busy), .o_done(done)
    );

    // Behavioural line buffer: stores writes, returns the next window one cycle after a read request
    logic [7:0] mem [M*W];
    int wr_ptr = 0, rd_k = 0;

    function automatic logic [WB-1:0] pack_mem(input int col);
        logic [WB-1:0] v = '0;
        for (int r = 0; r < M; r++)
            for (int j = 0; j < N; j++)
                v[(M * N - 1 - (r * N + j)) * 8 +: 8] = mem[r * W + col + j];
        return v;
    endfunction

    always @(posedge clk) begin
        if (start && !busy) begin
            wr_ptr <= 0;
            rd_k   <= 0;
        end else begin
            if (lb_dv) begin
                mem[wr_ptr] <= lb_data;
                wr_ptr      <= wr_ptr + 1;
            end
            if (lb_read) begin
                lb_win <= pack_mem(rd_k * MS);
                rd_k   <= rd_k + 1;
            end
        end
    end

    logic fin_en = 1'b0;
    assign lb_fin = fin_en && busy && (win_idx == 3'd1);

    // Upstream source: expected write bytes are queued when a beat is about to be accepted
    logic feed_en = 1'b0, gap_en = 1'b0;
    int beat_idx = 0, acc_cnt = 0, wr_seen = 0;
    logic [7:0] exp_wr[$];

    always @(negedge clk) begin
        if (!feed_en) begin
            s_valid = 1'b0;
        end else begin
            s_data  = beat_idx[7:0];
            s_valid = gap_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        if (s_valid && s_ready) begin
            exp_wr.push_back(s_data);
            beat_idx++;
            acc_cnt++;
        end
    end

    always @(negedge clk) begin
        if (lb_dv) begin
            chk("wr_q", 192'(exp_wr.size() > 0), 192'(1));
            if (exp_wr.size() > 0) chk("wr_data", 192'(lb_data), 192'(exp_wr.pop_front()));
            wr_seen++;
        end
        chk("rd_vs_wr", 192'(lb_read & lb_dv), 192'(0));
        chk("rd_vs_win", 192'(lb_read & win_valid), 192'(0));
    end

    // Downstream sink and window scoreboard
    logic stall_en = 1'b0, hs_prev = 1'b0;
    int hold_cnt = 0, wins = 0, done_cnt = 0;
    logic [WB-1:0] exp_win[$];
    int exp_idx[$];

    always @(negedge clk) begin
        if (!win_valid) hold_cnt = 0;
        win_ready = !stall_en || (win_valid && hold_cnt >= 5);
        if (win_valid) hold_cnt++;
        if (done) begin
            done_cnt++;
            chk("done_after_hs", 192'(hs_prev), 192'(1));
        end
        hs_prev = win_valid && win_ready;
        if (win_valid) begin
            chk("win_q", 192'(exp_win.size() > 0), 192'(1));
            if (exp_win.size() > 0) begin
                chk("win_data", 192'(win_data), 192'(exp_win[0]));
                chk("win_idx", 192'(win_idx), 192'(exp_idx[0]));
                if (win_ready) begin
                    void'(exp_win.pop_front());
                    void'(exp_idx.pop_front());
                    wins++;
                end
            end
        end
    end

    task automatic clear_sb();
        exp_wr.delete();
        exp_win.delete();
        exp_idx.delete();
        beat_idx = 0; acc_cnt = 0; wr_seen = 0; wins = 0; done_cnt = 0;
    endtask

    task automatic run_pass(input string tag, input int nwin, input logic gaps,
                            input logic stall, input logic poke, input logic fin);
        logic [191:0] t;
        clear_sb();
        gap_en = gaps; stall_en = stall; fin_en = fin;
        for (int k = 0; k < nwin; k++) begin
            t = mkwin(W, N, k * MS);
            exp_win.push_back(t[WB-1:0]);
            exp_idx.push_back(k);
        end
        feed_en = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done) begin start = 1'b0; break; end
            start = poke && win_valid && (c % 3 == 0);
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 192'(done), 192'(1));
        @(negedge clk);
        chk({tag, "_busy_low"}, 192'(busy), 192'(0));
        feed_en = 1'b0;
        repeat (3) @(negedge clk);
        chk({tag, "_beats"}, 192'(acc_cnt), 192'(M * W));
        chk({tag, "_writes"}, 192'(wr_seen), 192'(M * W));
        chk({tag, "_wins"}, 192'(wins), 192'(nwin));
        chk({tag, "_done_cnt"}, 192'(done_cnt), 192'(1));
        chk({tag, "_win_left"}, 192'(exp_win.size()), 192'(0));
        fin_en = 1'b0; stall_en = 1'b0; gap_en = 1'b0;
    endtask

    // Two further parameter sets, each with a free-running source and an always-ready sink
    logic aux_start = 1'b0, aux_feed = 1'b0;
    logic [7:0]   a1_sd = 8'd0, a2_sd = 8'd0, a1_lbd, a2_lbd;
    logic         a1_rdy, a2_rdy, a1_dv, a2_dv, a1_rd, a2_rd, a1_wv, a2_wv;
    logic         a1_busy, a2_busy, a1_done, a2_done;
    logic [191:0] a1_lbw = '0, a1_wd;
    logic [95:0]  a2_lbw = '0, a2_wd;
    logic [0:0]   a1_idx;
    logic [1:0]   a2_idx;
    logic [191:0] t2;
    int a1_beats = 0, a2_beats = 0, a1_k = 0, a2_k = 0, a1_ws = 0, a2_ws = 0;
    int a1_wins = 0, a2_wins = 0, a1_dc = 0, a2_dc = 0;
    logic [191:0] q1[$];
    logic [95:0]  q2[$];

    line_buffer_ctrl #(.M(3), .W(8), .n(8), .m(3), .SETTLE(1)) dut_a1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(aux_start),
        .s_data(a1_sd), .s_valid(aux_feed), .s_ready(a1_rdy),
        .o_lb_data(a1_lbd), .o_lb_data_valid(a1_dv), .o_lb_read(a1_rd),
        .i_lb_window(a1_lbw), .i_lb_finish_reading(1'b0),
        .o_win_data(a1_wd), .o_win_valid(a1_wv), .i_win_ready(1'b1),
        .o_win_idx(a1_idx), .o_busy(a1_busy), .o_done(a1_done)
    );

    line_buffer_ctrl #(.M(3), .W(9), .n(4), .m(2), .SETTLE(2)) dut_a2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(aux_start),
        .s_data(a2_sd), .s_valid(aux_feed), .s_ready(a2_rdy),
        .o_lb_data(a2_lbd), .o_lb_data_valid(a2_dv), .o_lb_read(a2_rd),
        .i_lb_window(a2_lbw), .i_lb_finish_reading(1'b0),
        .o_win_data(a2_wd), .o_win_valid(a2_wv), .i_win_ready(1'b1),
        .o_win_idx(a2_idx), .o_busy(a2_busy), .o_done(a2_done)
    );

    always @(posedge clk) begin
        if (aux_start && !a1_busy) a1_k <= 0;
        else if (a1_rd) begin
            a1_lbw <= mkwin(8, 8, a1_k * 3);
            a1_k   <= a1_k + 1;
        end
        if (aux_start && !a2_busy) a2_k <= 0;
        else if (a2_rd) begin
            t2      = mkwin(9, 4, a2_k * 2);
            a2_lbw <= t2[95:0];
            a2_k   <= a2_k + 1;
        end
    end

    always @(negedge clk) begin
        a1_sd = a1_beats[7:0];
        a2_sd = a2_beats[7:0];
        if (aux_feed && a1_rdy) a1_beats++;
        if (aux_feed && a2_rdy) a2_beats++;
        if (a1_dv) begin chk("a1_wr", 192'(a1_lbd), 192'(a1_ws[7:0])); a1_ws++; end
        if (a2_dv) begin chk("a2_wr", 192'(a2_lbd), 192'(a2_ws[7:0])); a2_ws++; end
        if (a1_done) a1_dc++;
        if (a2_done) a2_dc++;
        if (a1_wv) begin
            chk("a1_q", 192'(q1.size() > 0), 192'(1));
            if (q1.size() > 0) begin
                chk("a1_win", a1_wd, q1.pop_front());
                chk("a1_idx", 192'(a1_idx), 192'(a1_wins));
                a1_wins++;
            end
        end
        if (a2_wv) begin
            chk("a2_q", 192'(q2.size() > 0), 192'(1));
            if (q2.size() > 0) begin
                chk("a2_win", 192'(a2_wd), 192'(q2.pop_front()));
                chk("a2_idx", 192'(a2_idx), 192'(a2_wins));
                a2_wins++;
            end
        end
    end

    initial begin
        logic [191:0] t;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_s_ready", 192'(s_ready), 192'(0));
        chk("rst_busy", 192'(busy), 192'(0));
        chk("rst_done", 192'(done), 192'(0));
        chk("rst_lb_dv", 192'(lb_dv), 192'(0));
        chk("rst_lb_read", 192'(lb_read), 192'(0));
        chk("rst_win_valid", 192'(win_valid), 192'(0));
        chk("rst_win_data", 192'(win_data), 192'(0));
        chk("rst_win_idx", 192'(win_idx), 192'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_pass("basic", NW, 1'b0, 1'b0, 1'b0, 1'b0);
        run_pass("stall", NW, 1'b1, 1'b1, 1'b1, 1'b0);
        run_pass("finish", 2, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset partway through the fill abandons the pass
        clear_sb();
        feed_en = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 200 && acc_cnt < 15; c++) @(negedge clk);
        chk("mid_reached_15", 192'(acc_cnt), 192'(15));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        feed_en = 1'b0;
        chk("mid_busy", 192'(busy), 192'(0));
        chk("mid_s_ready", 192'(s_ready), 192'(0));
        chk("mid_lb_dv", 192'(lb_dv), 192'(0));
        chk("mid_win_idx", 192'(win_idx), 192'(0));
        chk("mid_win_data", 192'(win_data), 192'(0));
        exp_wr.delete();
        done_cnt = 0;
        repeat (5) @(negedge clk);
        chk("mid_no_done", 192'(done_cnt), 192'(0));
        run_pass("after_rst", NW, 1'b0, 1'b0, 1'b0, 1'b0);

        q1.push_back(mkwin(8, 8, 0));
        for (int k = 0; k < 3; k++) begin
            t = mkwin(9, 4, k * 2);
            q2.push_back(t[95:0]);
        end
        aux_feed = 1'b1;
        @(negedge clk); aux_start = 1'b1;
        @(negedge clk); aux_start = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (a1_dc > 0 && a2_dc > 0) break;
        end
        repeat (3) @(negedge clk);
        aux_feed = 1'b0;
        chk("a1_beats", 192'(a1_beats), 192'(24));
        chk("a2_beats", 192'(a2_beats), 192'(27));
        chk("a1_wins", 192'(a1_wins), 192'(1));
        chk("a2_wins", 192'(a2_wins), 192'(3));
        chk("a1_done_cnt", 192'(a1_dc), 192'(1));
        chk("a2_done_cnt", 192'(a2_dc), 192'(1));
        chk("a1_busy_end", 192'(a1_busy), 192'(0));
        chk("a2_busy_end", 192'(a2_busy), 192'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/line_buffer_ctrl.md
# line_buffer_ctrl

Sequencer for `line_buffer`. It accepts a pixel stream over a valid/ready handshake and forwards exactly M·W bytes into the buffer's write port. It then issues one-cycle read requests to extract every stride-m window of width n. Each captured M·n-byte window is presented downstream on a valid/ready handshake, and `o_done` is pulsed when the frame slice is exhausted.

## Interface
- `M`, 3, rows/channels held by the line buffer
- `W`, 10, row width in bytes
- `n`, 4, window width in bytes
- `m`, 2, window stride in bytes; must be ≥1, with n ≤ W
- `SETTLE`, 1, idle cycles between last write and first read; must be ≥1
- `i_clk`  in  1  clock, rising edge
- `i_rst_n`  in  1  reset; synchronous, active-low
- `i_start`  in  1  begin one fill/read pass; honoured only in IDLE
- `s_data`  in  8  input pixel
- `s_valid`  in  1  `s_data` valid
- `s_ready`  out  1  controller accepts `s_data`
- `o_lb_data`  out  8  to `line_buffer.i_data`
- `o_lb_data_valid`  out  1  to `line_buffer.i_data_valid`
- `o_lb_read`  out  1  to `line_buffer.output_needs_to_be_read`
- `i_lb_window`  in  M·n·8  from `line_buffer.o_data`
- `i_lb_finish_reading`  in  1  from `line_buffer.finish_reading`
- `o_win_data`  out  M·n·8  captured window
- `o_win_valid`  out  1  `o_win_data` valid
- `i_win_ready`  in  1  downstream accepts the window
- `o_win_idx`  out  clog2(NW+1)  index of the presented window
- `o_busy`  out  1  high in every state except IDLE
- `o_done`  out  1  one-cycle pulse at the end of a pass

## Operation
- NW = (W−n)/m + 1 (integer division); NW is 4 at the default parameters. Window k starts at column k·m.
- Write counter width is clog2(M·W+1). The counter counts accepted beats only.
- FSM states:
  - IDLE: `s_ready`=0. `i_start` moves to FILL and clears the counters.
  - FILL: `s_ready`=1. A beat is accepted when `s_valid`&&`s_ready`. Each accepted beat registers `o_lb_data`←`s_data` and sets `o_lb_data_valid`=1 for exactly the next cycle. On the M·W-th accepted beat, `s_ready` drops in the following cycle and the FSM moves to SETTLE.
  - SETTLE: count SETTLE cycles, then go to REQ.
  - REQ: `o_lb_read`=1 for this cycle only, then go to CAPT.
  - CAPT: `o_win_data`←`i_lb_window` and `o_win_valid`←1, then go to HOLD.
  - HOLD: `o_win_data` and `o_win_idx` are held stable while `o_win_valid`=1. When `o_win_valid`&&`i_win_ready`, clear `o_win_valid`. If `o_win_idx`==NW−1, or `i_lb_finish_reading`=1 was sampled in REQ/CAPT/HOLD of the current window, go to DONE. Otherwise increment `o_win_idx` and go to REQ.
  - DONE: `o_done`=1 for one cycle, then go to IDLE.
- `i_start` outside IDLE has no effect.
- `s_valid` while `s_ready`=0 is not consumed; data is held upstream.

## Timing
- Reset: when `i_rst_n`=0 at a clock edge, the state becomes IDLE and all outputs are 0 from the next edge. This includes `o_win_data`, `o_win_idx`, and the counters. Reset mid-pass abandons the pass; no `o_done` is generated.
- Write latency: `s_data` accepted at edge t appears on `o_lb_data` with `o_lb_data_valid`=1 during the cycle after t. Back-to-back beats give back-to-back writes.
- Read latency: `o_lb_read` is high in cycle r. `i_lb_window` is sampled at the end of cycle r+1. `o_win_valid` rises at cycle r+2.
- Minimum per-window period is 3 cycles (REQ, CAPT, HOLD with `i_win_ready`=1).
- `o_lb_read` never coincides with `o_lb_data_valid`, and it never fires while a window is unacknowledged.
- Last-window handshake and `o_done`: `o_done` is asserted in the cycle after the final handshake. `o_busy` is low from the cycle after `o_done`.
- `i_start` in the same cycle as `o_done`: ignored, because the FSM is not in IDLE. It is accepted on the next cycle if still high.

## Test plan
- Defaults, continuous `s_valid` with data = index mod 256, `i_win_ready`=1 → exactly 30 `o_lb_data_valid` pulses carrying 0..29, then 4 windows with idx 0..3 starting at columns 0, 2, 4, 6. Window 0 equals `{0,1,2,3, 10,11,12,13, 20,21,22,23}` packed MSB-first. Then a single `o_done`.
- Pseudo-random `s_valid` gaps and `i_win_ready` held low for 5 cycles per window → same data. `o_win_data` is stable while stalled. No `o_lb_read` pulses while a window is pending.
- `i_lb_finish_reading` forced to 1 during window 1 → the window 1 handshake completes, then DONE. Only 2 windows are emitted.
- Reset asserted for 1 cycle midway through FILL (beat 15) → all outputs 0. A new `i_start` then requires a full 30 beats, with no stale `o_done`.
- Parameters W=8, n=8, m=3 → NW=1: a single window at column 0, then `o_done`. W=9, n=4, m=2 → NW=3.
- `i_start` pulsed during READ phases, and `s_valid` held high in SETTLE/HOLD → ignored. Exactly M·W beats are accepted per pass.
